// File: rtl/latsnq_arc_driver_if.sv
// Control-side bundle for the latch arc driver:
// arc request in, status and result out.
interface latsnq_arc_driver_if #(
  parameter int CNT_W  = 8,
  parameter int FAIL_W = 8
);
  logic              START;
  logic [1:0]        ARC_SEL;
  logic              D_VAL;
  logic [CNT_W-1:0]  PW;
  logic [CNT_W-1:0]  SU;
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic [FAIL_W-1:0] FAIL_CNT;

  modport master (
    output START, ARC_SEL, D_VAL, PW, SU,
    input  BUSY, DONE, PASS, FAIL_CNT
  );

  modport slave (
    input  START, ARC_SEL, D_VAL, PW, SU,
    output BUSY, DONE, PASS, FAIL_CNT
  );
endinterface

// File: rtl/latsnq_arc_driver.sv
// Drives E/D/SETN of a set-latch through one timing arc
// per START and checks Q at the end of the arc.
module latsnq_arc_driver #(
  parameter int CNT_W  = 8,
  parameter int FAIL_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  latsnq_arc_driver_if.slave  ctl,
  output logic                E,
  output logic                D,
  output logic                SETN,
  input  logic                Q_IN
);

  typedef enum logic [2:0] {
    IDLE, PH_A, PH_B, PH_C, CHECK, FIN
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        arc_q, arc_u;
  logic              dv_q, dv_u;
  logic [CNT_W-1:0]  pw_q, su_q, pw_u, su_u;
  logic [CNT_W-1:0]  len_a, len_b, len_c;
  logic              pass_q, pass_n;
  logic [FAIL_W-1:0] fail_q, fail_n;
  logic [2:0]        pins_n;
  logic              acc;

  function automatic logic [CNT_W-1:0] clamp(
    input logic [CNT_W-1:0] x
  );
    return (x == '0) ? CNT_W'(1) : x;
  endfunction

  // Pin pattern {E, D, SETN} held during state st
  function automatic logic [2:0] drive(
    input logic [1:0] arc,
    input logic       dv,
    input state_t     st
  );
    logic [2:0] p;
    p = 3'b001;
    unique case (arc)
      2'd0: begin
        if (st == PH_A)
          p = {1'b1, ~dv, 1'b1};
        else if (st inside {PH_B, PH_C, CHECK})
          p = {1'b1, dv, 1'b1};
      end
      2'd1: begin
        if (st == PH_A)
          p = {1'b1, dv, 1'b1};
        else if (st == PH_B)
          p = {1'b0, dv, 1'b1};
        else if (st inside {PH_C, CHECK})
          p = {1'b0, ~dv, 1'b1};
      end
      2'd2: begin
        if (st == PH_A)
          p = 3'b000;
      end
      2'd3: begin
        if (st == PH_A)
          p = 3'b000;
        else if (st == PH_C)
          p = 3'b101;
      end
    endcase
    return p;
  endfunction

  function automatic logic exp_q(
    input logic [1:0] arc,
    input logic       dv
  );
    logic r;
    unique case (arc)
      2'd0, 2'd1: r = dv;
      2'd2:       r = 1'b1;
      2'd3:       r = 1'b0;
    endcase
    return r;
  endfunction

  assign acc   = (state == IDLE) && ctl.START;
  assign arc_u = acc ? ctl.ARC_SEL : arc_q;
  assign dv_u  = acc ? ctl.D_VAL : dv_q;
  assign pw_u  = acc ? clamp(ctl.PW) : pw_q;
  assign su_u  = acc ? clamp(ctl.SU) : su_q;

  assign len_a = (arc_u == 2'd1) ? su_u : pw_u;
  assign len_b = (arc_u == 2'd3) ? su_u : CNT_W'(1);
  assign len_c = pw_u;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pass_n  = pass_q;
    fail_n  = fail_q;
    unique case (state)
      IDLE: begin
        if (acc) begin
          state_n = PH_A;
          cnt_n   = len_a - CNT_W'(1);
          pass_n  = 1'b0;
        end
      end
      PH_A: begin
        if (cnt == '0) begin
          state_n = PH_B;
          cnt_n   = len_b - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PH_B: begin
        if (cnt == '0) begin
          state_n = PH_C;
          cnt_n   = len_c - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PH_C: begin
        if (cnt == '0) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      CHECK: begin
        state_n = FIN;
        pass_n  = (Q_IN == exp_q(arc_q, dv_q));
        if (Q_IN != exp_q(arc_q, dv_q) && fail_q != '1)
          fail_n = fail_q + FAIL_W'(1);
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    pins_n = drive(arc_u, dv_u, state_n);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      arc_q  <= '0;
      dv_q   <= 1'b0;
      pw_q   <= CNT_W'(1);
      su_q   <= CNT_W'(1);
      E      <= 1'b0;
      D      <= 1'b0;
      SETN   <= 1'b1;
      pass_q <= 1'b0;
      fail_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      {E, D, SETN} <= pins_n;
      pass_q <= pass_n;
      fail_q <= fail_n;
      if (acc) begin
        arc_q <= ctl.ARC_SEL;
        dv_q  <= ctl.D_VAL;
        pw_q  <= clamp(ctl.PW);
        su_q  <= clamp(ctl.SU);
      end
    end
  end

  assign ctl.BUSY     = state inside {PH_A, PH_B, PH_C, CHECK};
  assign ctl.DONE     = (state == FIN);
  assign ctl.PASS     = pass_q;
  assign ctl.FAIL_CNT = fail_q;

endmodule

// File: tb/tb_latsnq_arc_driver.sv
// Bench for latsnq_arc_driver: behavioural set-latch on the pins,
// per-cycle pin waveform model, vector table, random arcs.
module tb_latsnq_arc_driver;
  localparam int CNT_W  = 8;
  localparam int FAIL_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic e, d, setn, q_in;
  logic qm = 1'b0;
  logic lat;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  logic [FAIL_W-1:0] fail_model;

  latsnq_arc_driver_if #(.CNT_W(CNT_W), .FAIL_W(FAIL_W)) ctl ();

  latsnq_arc_driver #(.CNT_W(CNT_W), .FAIL_W(FAIL_W)) dut (
    .CLK  (clk),
    .RST  (rst),
    .ctl  (ctl),
    .E    (e),
    .D    (d),
    .SETN (setn),
    .Q_IN (q_in)
  );

  always #5 clk = ~clk;

  // Pins only move at posedge, so holding the latch state at negedge
  // gives an exact set-latch: SETN low forces 1, E high is transparent.
  assign lat  = !setn ? 1'b1 : (e ? d : qm);
  always @(negedge clk) qm <= lat;
  assign q_in = (mode == 1) ? d : (mode == 2) ? ~lat : lat;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic run_arc(
    input  logic [1:0] arc,
    input  logic       dv,
    input  logic [7:0] pw,
    input  logic [7:0] su,
    input  bit         poke,
    output logic       got_pass,
    output logic       model_pass
  );
    int la, lb, lc, tot, pw_e, su_e;
    logic [2:0] pa, pb, pc, pk, wp;
    logic eq, q_chk;
    pw_e = (pw == 0) ? 1 : int'(pw);
    su_e = (su == 0) ? 1 : int'(su);
    la  = (arc == 2'd1) ? su_e : pw_e;
    lb  = (arc == 2'd3) ? su_e : 1;
    lc  = pw_e;
    tot = la + lb + lc + 2;
    case (arc)
      2'd0: begin
        pa = {1'b1, ~dv, 1'b1}; pb = {1'b1, dv, 1'b1};
        pc = pb; pk = pb; eq = dv;
      end
      2'd1: begin
        pa = {1'b1, dv, 1'b1}; pb = {1'b0, dv, 1'b1};
        pc = {1'b0, ~dv, 1'b1}; pk = pc; eq = dv;
      end
      2'd2: begin
        pa = 3'b000; pb = 3'b001; pc = 3'b001; pk = 3'b001;
        eq = 1'b1;
      end
      default: begin
        pa = 3'b000; pb = 3'b001; pc = 3'b101; pk = 3'b001;
        eq = 1'b0;
      end
    endcase
    q_chk = 1'bx;
    ctl.START   = 1'b1;
    ctl.ARC_SEL = arc;
    ctl.D_VAL   = dv;
    ctl.PW      = pw;
    ctl.SU      = su;
    @(posedge clk); #1;
    ctl.START   = 1'b0;
    ctl.ARC_SEL = 2'($urandom);
    ctl.D_VAL   = 1'($urandom);
    ctl.PW      = 8'($urandom);
    ctl.SU      = 8'($urandom);
    for (int k = 1; k <= tot; k++) begin
      @(negedge clk);
      if (k <= la) wp = pa;
      else if (k <= la + lb) wp = pb;
      else if (k <= la + lb + lc) wp = pc;
      else if (k == tot - 1) wp = pk;
      else wp = 3'b001;
      chk($sformatf("pins arc%0d cyc%0d {E,D,SETN,BUSY,DONE}", arc, k),
          32'({e, d, setn, ctl.BUSY, ctl.DONE}),
          32'({wp, k < tot, k == tot}));
      if (k == tot - 1) q_chk = q_in;
      ctl.START = poke && (k == 2);
    end
    got_pass   = ctl.PASS;
    model_pass = (q_chk === eq);
    @(negedge clk);
    chk("idle after FIN {E,D,SETN,BUSY,DONE}",
        32'({e, d, setn, ctl.BUSY, ctl.DONE}), 32'(5'b00100));
  endtask

  typedef struct {
    logic [1:0] arc;
    logic       dv;
    logic [7:0] pw;
    logic [7:0] su;
    int         md;
    bit         poke;
    logic       pass;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic gp, mp;
    int dn;

    tbl[0] = '{2'd0, 1'b1, 8'd3, 8'd1, 0, 1'b0, 1'b1};
    tbl[1] = '{2'd1, 1'b0, 8'd4, 8'd2, 0, 1'b0, 1'b1};
    tbl[2] = '{2'd1, 1'b0, 8'd4, 8'd2, 1, 1'b0, 1'b0};
    tbl[3] = '{2'd2, 1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b1};
    tbl[4] = '{2'd3, 1'b0, 8'd2, 8'd3, 0, 1'b0, 1'b1};
    tbl[5] = '{2'd2, 1'b1, 8'd5, 8'd1, 0, 1'b1, 1'b1};
    tbl[6] = '{2'd0, 1'b0, 8'd0, 8'd0, 2, 1'b0, 1'b0};
    tbl[7] = '{2'd3, 1'b1, 8'd1, 8'd0, 1, 1'b1, 1'b1};
    tbl[8] = '{2'd1, 1'b1, 8'd2, 8'd0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    ctl.START = 1'b0; ctl.ARC_SEL = '0; ctl.D_VAL = 1'b0;
    ctl.PW = '0; ctl.SU = '0;
    fail_model = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset {E,D,SETN,BUSY,DONE,PASS}",
        32'({e, d, setn, ctl.BUSY, ctl.DONE, ctl.PASS}), 32'(6'b001000));
    chk("reset FAIL_CNT", 32'(ctl.FAIL_CNT), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mode = tbl[i].md;
      run_arc(tbl[i].arc, tbl[i].dv, tbl[i].pw, tbl[i].su,
              tbl[i].poke, gp, mp);
      if (!tbl[i].pass && fail_model != '1) fail_model++;
      chk($sformatf("vec%0d PASS", i), 32'(gp), 32'(tbl[i].pass));
      chk($sformatf("vec%0d FAIL_CNT", i),
          32'(ctl.FAIL_CNT), 32'(fail_model));
    end

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(2));
      run_arc(2'($urandom), 1'($urandom), 8'($urandom_range(6)),
              8'($urandom_range(6)), 1'($urandom), gp, mp);
      if (!mp && fail_model != '1) fail_model++;
      chk($sformatf("rnd%0d PASS", i), 32'(gp), 32'(mp));
      chk($sformatf("rnd%0d FAIL_CNT", i),
          32'(ctl.FAIL_CNT), 32'(fail_model));
    end

    // Reset during PH_C of a would-fail arc 0 (A=4, B=1, C=6..9)
    mode = 2;
    ctl.START = 1'b1; ctl.ARC_SEL = 2'd0; ctl.D_VAL = 1'b1;
    ctl.PW = 8'd4; ctl.SU = 8'd1;
    @(posedge clk); #1;
    ctl.START = 1'b0;
    repeat (6) @(negedge clk);
    chk("in PH_C before reset {E,D,SETN,BUSY}",
        32'({e, d, setn, ctl.BUSY}), 32'(4'b1111));
    rst = 1'b1;
    @(negedge clk);
    chk("mid-arc reset {E,D,SETN,BUSY,DONE,PASS}",
        32'({e, d, setn, ctl.BUSY, ctl.DONE, ctl.PASS}), 32'(6'b001000));
    rst = 1'b0;
    fail_model = '0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ctl.DONE || ctl.BUSY) dn++;
    end
    chk("no DONE/BUSY after abort", 32'(dn), 32'd0);
    chk("FAIL_CNT after abort", 32'(ctl.FAIL_CNT), 32'd0);

    mode = 2;
    for (int i = 0; i < 300; i++) begin
      run_arc(2'd2, 1'b0, 8'd1, 8'd1, 1'b0, gp, mp);
      if (!mp && fail_model != '1) fail_model++;
    end
    chk("forced-fail PASS", 32'(gp), 32'd0);
    chk("saturated FAIL_CNT", 32'(ctl.FAIL_CNT), 32'(fail_model));
    chk("saturated FAIL_CNT all-ones", 32'(ctl.FAIL_CNT), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/latsnq_arc_driver.md
Name: latsnq_arc_driver

Overview:
- Synchronous stimulus/check engine that drives the E, D and SETN pins of a set-latch cell (active-low set, transparent-high enable) and checks its Q output.
- Runs one timing arc per START: transparent D->Q, capture on E fall, SETN set, or SETN recovery.
- Sits in the cell-library silicon/emulation characterization harness, on the driving side of the latch pins.

Parameters:
- CNT_W, 8, width of the programmable phase-length inputs PW and SU.
- FAIL_W, 8, width of the saturating failure counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request to run an arc; sampled only in IDLE.
- ARC_SEL  input  2  0=DQ, 1=CAPTURE, 2=SET, 3=RECOVERY.
- D_VAL  input  1  data value under test (arcs 0/1).
- PW  input  CNT_W  pulse/phase length in cycles.
- SU  input  CNT_W  setup/recovery length in cycles.
- E  output  1  registered latch enable to DUT.
- D  output  1  registered latch data to DUT.
- SETN  output  1  registered active-low set to DUT.
- Q_IN  input  1  DUT Q output.
- BUSY  output  1  high from the cycle after START acceptance through CHECK.
- DONE  output  1  one-cycle pulse after CHECK.
- PASS  output  1  result of last arc; valid with DONE, held until next accepted START.
- FAIL_CNT  output  FAIL_W  saturating count of failed arcs.

Behaviour:
- Reset values: E=0, D=0, SETN=1, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, state IDLE.
- RST asserted mid-arc: next edge returns to reset values; the arc is aborted; FAIL_CNT is not incremented.
- States: IDLE -> PH_A -> PH_B -> PH_C -> CHECK -> FIN -> IDLE.
- START in IDLE latches ARC_SEL, D_VAL, PW and SU. PW=0 or SU=0 is treated as 1.
- START outside IDLE is ignored.
- Outputs are registered: the drive values for a phase appear on the first cycle of that phase.
- Phase lengths: PH_A = PW (arc 1: SU); PH_B = 1 (arc 3: SU); PH_C = PW; CHECK = 1; FIN = 1.
- Total from START edge to DONE: A+B+C+2 cycles after the accepting edge.
- Drive table (E, D, SETN per phase):
  - Arc 0 DQ: A: 1, ~D_VAL, 1. B: 1, D_VAL, 1. C and CHECK: 1, D_VAL, 1. Expected Q = D_VAL.
  - Arc 1 CAPTURE: A: 1, D_VAL, 1. B (hold): 0, D_VAL, 1. C and CHECK: 0, ~D_VAL, 1. Expected Q = D_VAL.
  - Arc 2 SET: A: 0, 0, 0. B and C and CHECK: 0, 0, 1. Expected Q = 1.
  - Arc 3 RECOVERY: A: 0, 0, 0. B: 0, 0, 1. C: 1, 0, 1. CHECK: 0, 0, 1. Expected Q = 0.
- CHECK: Q_IN is sampled at the rising edge ending CHECK.
  - PASS <= (Q_IN == expected).
  - On mismatch, FAIL_CNT increments and saturates at all-ones.
- FIN: DONE=1 for one cycle. Outputs return to idle values (E=0, D=0, SETN=1). BUSY=0.
- Back-to-back operation: START asserted in the cycle after FIN is accepted.
- Phase counter: CNT_W bits, loads length-1 on phase entry, advances the phase at 0. Maximum phase length is 2^CNT_W-1 cycles, with no wrap.
- ARC_SEL, D_VAL, PW and SU changing while BUSY have no effect.

Test Plan:
- Reset, then arc 0, D_VAL=1, PW=3, DUT model ideal. Required: D=0 for 3 cycles, then D=1 with E=1; DONE 9 cycles after the START edge; PASS=1; FAIL_CNT=0.
- Arc 1, D_VAL=0, SU=2, PW=4. Required: E falls with D still 0 for 1 cycle, then D=1 with Q_IN held 0; PASS=1.
- Same arc 1 with the DUT model forced transparent (Q follows D). Required: PASS=0, FAIL_CNT=1.
- Arc 2, PW=0 (treated as 1). Required: SETN low for exactly 1 cycle; Q_IN=1 at CHECK; PASS=1.
- Arc 3, PW=2, SU=3. Required: SETN high 3 cycles before E rises; PASS=1.
- START pulsed while BUSY is ignored. RST asserted during PH_C returns E=0, D=0, SETN=1, BUSY=0 next cycle with no DONE. 300 forced failures leave FAIL_CNT=255.
